// File: rtl/beta_pkg.sv
// beta_pkg: constants and cache state type shared by the fetch stage and the instruction cache
package beta_pkg;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int LINE_WORDS = 4;
  typedef enum logic [1:0] {IDLE, REQ, FILL} cache_state_e;
endpackage

// File: rtl/cache_array.sv
// cache_array: valid/tag/data storage with combinational read and synchronous writes
module cache_array
  import beta_pkg::*;
#(
  parameter int INDEX_W = 4,
  parameter int TAG_W = 28 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [1:0]         rd_offset,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               clear,
  input  logic               tv_we,
  input  logic [INDEX_W-1:0] tv_index,
  input  logic [TAG_W-1:0]   tv_tag,
  input  logic               tv_valid,
  input  logic               w_we,
  input  logic [INDEX_W-1:0] w_index,
  input  logic [1:0]         w_offset,
  input  logic [31:0]        w_data
);
  localparam int LINES = 1 << INDEX_W;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES][LINE_WORDS];
  always_comb begin
    rd_valid = valid[rd_index];
    rd_tag = tags[rd_index];
    rd_data = data[rd_index][rd_offset];
  end
  // clear-all wins over a same-cycle tag/valid write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= '0;
    else if (clear) valid <= '0;
    else if (tv_we) valid[tv_index] <= tv_valid;
  end
  always_ff @(posedge clk) begin
    if (tv_we) tags[tv_index] <= tv_tag;
    if (w_we) data[w_index][w_offset] <= w_data;
  end
endmodule

// File: rtl/imem_cache.sv
// imem_cache: direct-mapped read-only instruction cache with 4-word line refill
module imem_cache
  import beta_pkg::*;
#(
  parameter int INDEX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_mem_addr,
  output logic [31:0] i_mem_data,
  output logic        i_mem_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);
  localparam int TAG_W = 28 - INDEX_W;
  cache_state_e state, state_n;
  logic [27:0] line_addr;
  logic [1:0] cnt;
  logic flush_pending, hit, last, pend, rd_valid, unused;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0] rd_data;
  assign unused = ^i_mem_addr[1:0];
  cache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (i_mem_addr[INDEX_W+3:4]),
    .rd_offset(i_mem_addr[3:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .clear    ((state == IDLE && flush) || (last && pend)),
    .tv_we    (last),
    .tv_index (line_addr[INDEX_W-1:0]),
    .tv_tag   (line_addr[27:INDEX_W]),
    .tv_valid (!pend),
    .w_we     (state == FILL && mem_rvalid),
    .w_index  (line_addr[INDEX_W-1:0]),
    .w_offset (cnt),
    .w_data   (mem_rdata)
  );
  always_comb begin
    hit = rd_valid && rd_tag == i_mem_addr[31:INDEX_W+4];
    last = state == FILL && mem_rvalid && cnt == 2'd3;
    pend = flush_pending || flush;
    i_mem_stall = state != IDLE || !hit;
    i_mem_data = i_mem_stall ? INST_NOP : rd_data;
    mem_req = state == REQ;
    mem_addr = {line_addr, 4'b0};
    state_n = state == IDLE ? (hit ? IDLE : REQ) :
              state == REQ  ? (mem_gnt ? FILL : REQ) :
              (last ? IDLE : FILL);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      line_addr <= '0;
      cnt <= '0;
      flush_pending <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && !hit) line_addr <= i_mem_addr[31:4];
      if (state == REQ && mem_gnt) cnt <= '0;
      else if (state == FILL && mem_rvalid) cnt <= cnt + 2'd1;
      // a flush seen mid-refill is held until the burst lands, then clears everything
      flush_pending <= state != IDLE && !last && pend;
    end
  end
endmodule

// File: tb/tb_imem_cache.sv
// tb_imem_cache: scenario tasks plus randomized fetches checked against a line-level cache model
module tb_imem_cache;
  import beta_pkg::*;
  logic clk = 0, rst_n, flush, mem_req, mem_gnt, mem_rvalid, i_mem_stall;
  logic [31:0] i_mem_addr, i_mem_data, mem_addr, mem_rdata;
  int tests = 0, fails = 0;
  bit ok, bad;
  logic [31:0] ra;
  bit mv [16];
  logic [23:0] mt [16];
  logic [31:0] md [16][4];

  always #5 clk = ~clk;

  imem_cache dut (
    .clk(clk), .rst_n(rst_n), .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
    .i_mem_stall(i_mem_stall), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bit mhit(input logic [31:0] a);
    return mv[a[7:4]] && mt[a[7:4]] == a[31:8];
  endfunction

  function automatic logic [31:0] mexp(input logic [31:0] a);
    return mhit(a) ? md[a[7:4]][a[3:2]] : INST_NOP;
  endfunction

  function automatic logic [31:0] bdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic mclear();
    for (int i = 0; i < 16; i++) mv[i] = 0;
  endtask

  task automatic mfill(input logic [31:0] a, input logic [3:0][31:0] d);
    mv[a[7:4]] = 1;
    mt[a[7:4]] = a[31:8];
    for (int w = 0; w < 4; w++) md[a[7:4]][w] = d[w];
  endtask

  // memory-side responder: waits for the request, grants after gd cycles, then
  // delivers the four beats with rvalid following pat for the first plen cycles
  task automatic refill(input logic [3:0][31:0] d, input int gd, input logic [7:0] pat,
                        input int plen, input bit fl, output bit rok, output logic [31:0] rra,
                        output bit rbad);
    int n, k, c;
    rok = 1; rbad = 0; rra = 'x; n = 0;
    while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
    if (!mem_req) begin rok = 0; return; end
    rra = mem_addr;
    repeat (gd) begin
      if (!mem_req || !i_mem_stall) rbad = 1;
      @(posedge clk); #1;
    end
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    if (mem_req) rbad = 1;
    k = 0; c = 0;
    while (k < 4 && c < 40) begin
      mem_rvalid = (c < plen) ? pat[c] : 1'b1;
      mem_rdata = mem_rvalid ? d[k] : $urandom;
      flush = fl && c == 0;
      if (!i_mem_stall || mem_req || mem_addr !== rra) rbad = 1;
      @(posedge clk); #1;
      if (mem_rvalid) k++;
      c++;
    end
    mem_rvalid = 0;
    flush = 0;
    if (k < 4) rok = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    i_mem_addr = 32'h10;
    mclear();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (i_mem_stall !== 1 || mem_req !== 0 || mem_addr !== 0 || i_mem_data !== INST_NOP) begin
      fails++;
      $display("FAIL reset: stall=%b req=%b addr=%h data=%h, want 1 0 0 %h",
               i_mem_stall, mem_req, mem_addr, i_mem_data, INST_NOP);
    end
    rst_n = 1;
  endtask

  task automatic test_cold_miss();
    logic [3:0][31:0] d = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    refill(d, 2, 8'hFF, 0, 0, ok, ra, bad);
    tests++;
    if (!ok || bad || ra !== 32'h10) begin
      fails++;
      $display("FAIL cold_refill: ok=%b bad=%b mem_addr=%h, want 1 0 00000010", ok, bad, ra);
    end
    mfill(32'h10, d);
    tests++;
    if (i_mem_stall !== 0 || i_mem_data !== 32'hA0) begin
      fails++;
      $display("FAIL cold_hit: stall=%b data=%h, want 0 000000a0", i_mem_stall, i_mem_data);
    end
  endtask

  task automatic test_line_hits();
    for (int i = 1; i < 4; i++) begin
      i_mem_addr = 32'h10 + 32'(4 * i);
      #1;
      tests++;
      if (i_mem_stall !== 0 || mem_req !== 0 || i_mem_data !== mexp(i_mem_addr)) begin
        fails++;
        $display("FAIL line_hit %h: stall=%b req=%b data=%h, want 0 0 %h",
                 i_mem_addr, i_mem_stall, mem_req, i_mem_data, mexp(i_mem_addr));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_conflict();
    logic [3:0][31:0] b = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    logic [3:0][31:0] a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    i_mem_addr = 32'h110;
    #1;
    tests++;
    if (i_mem_stall !== 1) begin
      fails++;
      $display("FAIL conflict_miss: stall=%b, want 1", i_mem_stall);
    end
    refill(b, 1, 8'hFF, 0, 0, ok, ra, bad);
    mfill(32'h110, b);
    tests++;
    if (!ok || bad || ra !== 32'h110 || i_mem_stall !== 0 || i_mem_data !== 32'hB0) begin
      fails++;
      $display("FAIL conflict_fill: ok=%b bad=%b addr=%h stall=%b data=%h, want 1 0 00000110 0 000000b0",
               ok, bad, ra, i_mem_stall, i_mem_data);
    end
    @(posedge clk); #1;
    i_mem_addr = 32'h10;
    #1;
    tests++;
    if (i_mem_stall !== 1) begin
      fails++;
      $display("FAIL evicted_miss: stall=%b, want 1", i_mem_stall);
    end
    refill(a, 0, 8'hFF, 0, 0, ok, ra, bad);
    mfill(32'h10, a);
    tests++;
    if (!ok || bad || i_mem_data !== 32'hA0) begin
      fails++;
      $display("FAIL evicted_refill: ok=%b bad=%b data=%h, want 1 0 000000a0", ok, bad, i_mem_data);
    end
  endtask

  task automatic test_gapped();
    logic [3:0][31:0] d = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    i_mem_addr = 32'h20;
    refill(d, 0, 8'b0101_1001, 7, 0, ok, ra, bad);
    mfill(32'h20, d);
    tests++;
    if (!ok || bad || ra !== 32'h20) begin
      fails++;
      $display("FAIL gapped_refill: ok=%b bad=%b addr=%h, want 1 0 00000020", ok, bad, ra);
    end
    for (int w = 0; w < 4; w++) begin
      i_mem_addr = 32'h20 + 32'(4 * w);
      #1;
      tests++;
      if (i_mem_stall !== 0 || i_mem_data !== mexp(i_mem_addr)) begin
        fails++;
        $display("FAIL gapped_word %0d: stall=%b data=%h, want 0 %h", w, i_mem_stall, i_mem_data,
                 mexp(i_mem_addr));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_idle();
    logic [3:0][31:0] a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    i_mem_addr = 32'h10;
    flush = 1;
    #1;
    tests++;
    if (i_mem_stall !== 0 || i_mem_data !== 32'hA0) begin
      fails++;
      $display("FAIL flush_same_cycle: stall=%b data=%h, want 0 000000a0", i_mem_stall, i_mem_data);
    end
    @(posedge clk); #1;
    flush = 0;
    mclear();
    tests++;
    if (i_mem_stall !== 1 || i_mem_data !== INST_NOP) begin
      fails++;
      $display("FAIL flush_idle_miss: stall=%b data=%h, want 1 %h", i_mem_stall, i_mem_data, INST_NOP);
    end
    refill(a, 0, 8'hFF, 0, 0, ok, ra, bad);
    mfill(32'h10, a);
  endtask

  task automatic test_flush_fill();
    logic [3:0][31:0] d = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    logic [3:0][31:0] a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    i_mem_addr = 32'h30;
    refill(d, 1, 8'hFF, 0, 1, ok, ra, bad);
    mclear();
    tests++;
    if (!ok || bad || i_mem_stall !== 1 || i_mem_data !== INST_NOP) begin
      fails++;
      $display("FAIL flush_fill: ok=%b bad=%b stall=%b data=%h, want 1 0 1 %h",
               ok, bad, i_mem_stall, i_mem_data, INST_NOP);
    end
    refill(d, 0, 8'hFF, 0, 0, ok, ra, bad);
    mfill(32'h30, d);
    tests++;
    if (!ok || i_mem_stall !== 0 || i_mem_data !== 32'hD0) begin
      fails++;
      $display("FAIL flush_fill_retry: ok=%b stall=%b data=%h, want 1 0 000000d0", ok, i_mem_stall, i_mem_data);
    end
    @(posedge clk); #1;
    i_mem_addr = 32'h10;
    #1;
    tests++;
    if (i_mem_stall !== 1) begin
      fails++;
      $display("FAIL flush_fill_all: stall=%b for 00000010, want 1", i_mem_stall);
    end
    refill(a, 0, 8'hFF, 0, 0, ok, ra, bad);
    mfill(32'h10, a);
  endtask

  task automatic test_reset_mid_fill();
    logic [3:0][31:0] e = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    int n = 0;
    i_mem_addr = 32'h40;
    while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
    tests++;
    if (!mem_req) begin
      fails++;
      $display("FAIL rst_fill_req: mem_req=%b, want 1", mem_req);
    end
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1; mem_rdata = 32'hDEAD_0000 + 32'(k);
      @(posedge clk); #1;
    end
    rst_n = 0;
    #1;
    mclear();
    tests++;
    if (mem_req !== 0 || i_mem_stall !== 1) begin
      fails++;
      $display("FAIL rst_mid_fill: req=%b stall=%b, want 0 1", mem_req, i_mem_stall);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    mem_rvalid = 0;
    refill(e, 0, 8'hFF, 0, 0, ok, ra, bad);
    mfill(32'h40, e);
    tests++;
    if (!ok || bad || ra !== 32'h40) begin
      fails++;
      $display("FAIL rst_refill: ok=%b bad=%b addr=%h, want 1 0 00000040", ok, bad, ra);
    end
    for (int w = 0; w < 4; w++) begin
      i_mem_addr = 32'h40 + 32'(4 * w);
      #1;
      tests++;
      if (i_mem_stall !== 0 || i_mem_data !== mexp(i_mem_addr)) begin
        fails++;
        $display("FAIL rst_refill_word %0d: stall=%b data=%h, want 0 %h", w, i_mem_stall, i_mem_data,
                 mexp(i_mem_addr));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0][31:0] d;
    bit h, fl;
    for (int it = 0; it < 80; it++) begin
      a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          32'($urandom_range(0, 15));
      fl = $urandom_range(0, 7) == 0;
      i_mem_addr = a;
      flush = fl;
      #1;
      h = mhit(a);
      tests++;
      if (i_mem_stall !== !h || i_mem_data !== mexp(a)) begin
        fails++;
        $display("FAIL random %0d addr=%h: stall=%b data=%h, want %b %h", it, a, i_mem_stall,
                 i_mem_data, !h, mexp(a));
      end
      @(posedge clk); #1;
      flush = 0;
      if (fl) mclear();
      if (!h) begin
        for (int w = 0; w < 4; w++) d[w] = bdata({a[31:4], 2'(w), 2'b0});
        refill(d, $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 8), 0, ok, ra, bad);
        mfill(a, d);
        tests++;
        if (!ok || bad || ra !== {a[31:4], 4'b0} || i_mem_stall !== 0 || i_mem_data !== mexp(a)) begin
          fails++;
          $display("FAIL random_refill %0d addr=%h: ok=%b bad=%b mem_addr=%h stall=%b data=%h, want 1 0 %h 0 %h",
                   it, a, ok, bad, ra, i_mem_stall, i_mem_data, {a[31:4], 4'b0}, mexp(a));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_line_hits();
    test_conflict();
    test_gapped();
    test_flush_idle();
    test_flush_fill();
    test_reset_mid_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_cache.md
# imem_cache

Direct-mapped, read-only instruction cache that answers the fetch stage's instruction-memory port and refills lines from a slower backing memory. The fetch stage presents a byte address every cycle. On a hit the cache returns the instruction combinationally in the same cycle. On a miss it raises a stall, bursts a 4-word line in from backing memory, and then serves the hit. The block sits between the fetch stage and the system memory bus.

## Interface
- INDEX_W, default 4: line-index bits; the cache holds 2**INDEX_W lines of 4 × 32-bit words.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_mem_addr  in  32  fetch byte address; bits [1:0] are ignored.
- i_mem_data  out  32  instruction word; equals INST_NOP while i_mem_stall=1.
- i_mem_stall  out  1  high whenever the current i_mem_addr misses or a refill is in progress.
- flush  in  1  invalidate all lines.
- mem_req  out  1  line read request, held until granted.
- mem_addr  out  32  line-aligned address {tag,index,4'b0}.
- mem_gnt  in  1  backing memory accepts the request.
- mem_rdata  in  32  refill beat data.
- mem_rvalid  in  1  beat valid; beats arrive in word order 0..3 and may have gaps.

## Operation
- Address split:
  - offset = addr[3:2]
  - index = addr[INDEX_W+3:4]
  - tag = addr[31:INDEX_W+4]
- Hit when valid[index] is set and tag_array[index] equals tag.
- FSM states:
  - IDLE: hit → i_mem_stall=0 and i_mem_data=data[index][offset]. Miss → latch the line address and go to REQ.
  - REQ: mem_req=1 and mem_addr=latched line address. On mem_gnt=1, go to FILL with beat counter = 0.
  - FILL: each mem_rvalid writes mem_rdata into data[latched index][counter] and increments the counter. On the 4th beat, write the tag, set valid (unless a flush is pending), and return to IDLE.
- i_mem_stall = (state != IDLE) OR miss.
- The refill always targets the latched address, even if i_mem_addr changes mid-refill. After returning to IDLE, the cache re-looks-up whatever address is present.
- flush:
  - In IDLE: clears every valid bit at the next edge. A lookup in the same cycle still uses the pre-flush valids.
  - In REQ or FILL: sets flush_pending. The burst completes, valid is not set for the refilled line, all valids are cleared on return to IDLE, and flush_pending is cleared.
- A mem_rvalid seen outside FILL is ignored.
- A mem_gnt seen outside REQ is ignored.
- Eviction is implicit: a conflicting line overwrites data and tag at the same index.

## Timing
- Reset (asynchronous): state=IDLE, all valid=0, mem_req=0, mem_addr=0, beat counter=0, flush_pending=0.
  - i_mem_stall=1 immediately after reset, because every lookup misses.
  - Deasserting rst_n mid-refill abandons the burst. Any beats still in flight are dropped, since rvalid is ignored outside FILL.
- Hit latency: 0 cycles (combinational address→data).
- Miss timing:
  - Cycle 0: miss detected, i_mem_stall=1.
  - Cycle 1: mem_req=1.
  - mem_req drops in the cycle after mem_gnt is sampled high.
- Refill penalty: i_mem_stall deasserts in the cycle after the 4th beat, provided the address is unchanged. The minimum miss is 7 cycles with gnt in cycle 1 and back-to-back rvalid in cycles 2–5, so the hit occurs in cycle 6.
- mem_addr is stable from the cycle mem_req rises until the 4th beat.

## Structure
- Shared package (beta_pkg) holds the following, which are also used by the fetch stage:
  - INST_NOP
  - LINE_WORDS=4
  - The cache state enum: IDLE/REQ/FILL
- Sub-module cache_array: valid/tag/data storage with a combinational read port and synchronous write ports (tag/valid write, word write, clear-all).
  - Reset affects valid bits only.
  - The FSM lives in imem_cache.

## Test plan
- Cold miss: after reset, address 0x00000010; grant after 2 cycles; beats 0xA0..0xA3 → mem_addr=0x00000010; stall until the cycle after beat 3; i_mem_data=0xA0.
- Line hits: following the fill above, addresses 0x14, 0x18, 0x1C → data 0xA1, 0xA2, 0xA3 with stall=0 and no mem_req.
- Conflict: with INDEX_W=4, fetch 0x00000110 (same index 1, different tag) → refill; then 0x10 misses again.
- Gapped beats: rvalid pattern 1,0,0,1,1,0,1 → all four words are stored correctly; stall drops only after the 4th beat.
- Flush:
  - Flush in IDLE → the next lookup of 0x10 misses.
  - Flush during FILL → the burst completes, the line is not valid, and 0x10 misses again.
- Reset mid-FILL after 2 beats → mem_req=0 and stall=1; the remaining beats are ignored; the following fetch performs a full 4-beat refill.
